// File: rtl/tweaked_enc_fifo_pkg.sv
// Shared helpers for the tweaked encrypted FIFO: sequence tweak, parity tag
// and occupancy-counter width.
package tweaked_enc_fifo_pkg;

  // Widest data path the helpers support; callers cast down to their own width.
  localparam int MAX_W = 1024;

  function automatic logic [MAX_W-1:0] tweak(input logic [7:0] seq);
    return {(MAX_W/8){seq}};
  endfunction

  // Folds all bytes together, then reduces; zero-extension does not change it.
  function automatic logic byte_parity(input logic [MAX_W-1:0] data);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < MAX_W/8; i++) acc ^= data[i*8 +: 8];
    return ^acc;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/enc_fifo_ram.sv
// Ciphertext + tag storage: one write port, one registered read port.
// Storage is not reset; only the read register is.
module enc_fifo_ram #(
  parameter int W     = 129,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Same-address read and write returns the old word (read-before-write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/tweaked_encrypted_fifo.sv
// FIFO that stores only ciphertext: plain ^ key ^ tweak(seq) on write, inverse on
// read, with a parity tag per word. Handshake: wr/rd accepted in the cycle issued.
module tweaked_encrypted_fifo
  import tweaked_enc_fifo_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] secret_key,
  input  logic              key_load,
  input  logic [DATA_W-1:0] plain_data_in,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] plain_data_out,
  output logic              rd_valid_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [CW-1:0]     count_o,
  output logic              overflow_o,
  output logic              underflow_o,
  output logic              key_rej_o,
  output logic              tag_err_o
);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [7:0]        r_wr_seq, r_rd_seq;
  logic [DATA_W-1:0] r_key, r_rd_mask;
  logic [CW-1:0]     r_count;
  logic              r_full, r_empty, r_afull, r_aempty;
  logic              r_ovf, r_udf, r_krej, r_rd_valid;

  logic              w_rd_acc, w_wr_acc, w_key_acc;
  logic [CW-1:0]     w_cnt_nxt;
  logic [DATA_W-1:0] w_cipher, w_plain_rd;
  logic              w_wr_tag;
  logic [DATA_W:0]   w_ram_q;

  assign w_rd_acc  = rd_en & ~r_empty;
  assign w_wr_acc  = wr_en & (~r_full | w_rd_acc);
  assign w_key_acc = key_load & r_empty & ~wr_en;

  assign w_cipher = plain_data_in ^ r_key ^ DATA_W'(tweak(r_wr_seq));
  assign w_wr_tag = byte_parity(MAX_W'(plain_data_in));

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_wr_acc && !w_rd_acc)      w_cnt_nxt = r_count + 1'b1;
    else if (w_rd_acc && !w_wr_acc) w_cnt_nxt = r_count - 1'b1;
  end

  enc_fifo_ram #(.W(DATA_W + 1), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data ({w_wr_tag, w_cipher}),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_wr_seq   <= '0;
      r_rd_seq   <= '0;
      r_key      <= '0;
      r_rd_mask  <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_afull    <= 1'b0;
      r_aempty   <= 1'b1;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
      r_krej     <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_wr_seq <= r_wr_seq + 8'd1;
      end
      // The mask is captured with the read so the output holds even if the key changes later.
      if (w_rd_acc) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rd_seq  <= r_rd_seq + 8'd1;
        r_rd_mask <= r_key ^ DATA_W'(tweak(r_rd_seq));
      end
      if (w_key_acc) r_key <= secret_key;
      r_count    <= w_cnt_nxt;
      r_full     <= (w_cnt_nxt == DEPTH_C);
      r_empty    <= (w_cnt_nxt == '0);
      r_afull    <= (w_cnt_nxt >= AFULL_C);
      r_aempty   <= (w_cnt_nxt <= AEMPTY_C);
      r_ovf      <= r_ovf  | (wr_en & ~w_wr_acc);
      r_udf      <= r_udf  | (rd_en & ~w_rd_acc);
      r_krej     <= r_krej | (key_load & ~w_key_acc);
      r_rd_valid <= w_rd_acc;
    end
  end

  // Output is a pure XOR of two registers, so it is stable for the whole cycle.
  assign w_plain_rd     = w_ram_q[DATA_W-1:0] ^ r_rd_mask;
  assign plain_data_out = w_plain_rd;
  assign rd_valid_o     = r_rd_valid;
  assign tag_err_o      = r_rd_valid & (byte_parity(MAX_W'(w_plain_rd)) != w_ram_q[DATA_W]);
  assign full_o         = r_full;
  assign empty_o        = r_empty;
  assign almost_full_o  = r_afull;
  assign almost_empty_o = r_aempty;
  assign count_o        = r_count;
  assign overflow_o     = r_ovf;
  assign underflow_o    = r_udf;
  assign key_rej_o      = r_krej;

endmodule

// File: tb/tb_tweaked_encrypted_fifo.sv
// Directed bench for tweaked_encrypted_fifo with hand-computed expectations.
module tb_tweaked_encrypted_fifo;

  localparam int DW = 128;
  localparam logic [DW-1:0] KEY1 = 128'hDEADBEEF_CAFEBABE_0123_4567_89AB_CDEF;
  localparam logic [DW-1:0] KEY2 = 128'h0F1E2D3C_4B5A6978_8796_A5B4_C3D2_E1F0;
  // KEY1 ^ {16{8'h01}} ^ 1
  localparam logic [DW-1:0] CIPH1 = 128'hDFACBFEE_CBFFBBBF_0022_4466_88AA_CCEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] secret_key = '0;
  logic          key_load = 1'b0;
  logic [DW-1:0] plain_data_in = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] plain_data_out;
  logic          rd_valid_o, full_o, empty_o, almost_full_o, almost_empty_o;
  logic [4:0]    count_o;
  logic          overflow_o, underflow_o, key_rej_o, tag_err_o;

  int n_cmp = 0;
  int n_err = 0;

  tweaked_encrypted_fifo u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .secret_key     (secret_key),
    .key_load       (key_load),
    .plain_data_in  (plain_data_in),
    .wr_en          (wr_en),
    .rd_en          (rd_en),
    .plain_data_out (plain_data_out),
    .rd_valid_o     (rd_valid_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o),
    .key_rej_o      (key_rej_o),
    .tag_err_o      (tag_err_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [DW-1:0] d);
    plain_data_in = d;
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [DW-1:0] exp);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check_eq({tag, "_valid"}, DW'(rd_valid_o), 1);
    check_eq({tag, "_data"}, plain_data_out, exp);
    check_eq({tag, "_tagerr"}, DW'(tag_err_o), 0);
  endtask

  task automatic load_key(input logic [DW-1:0] k);
    secret_key = k;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
  endtask

  initial begin
    logic [3:0] idx;
    step();
    step();
    check_eq("rst_empty", DW'(empty_o), 1);
    check_eq("rst_aempty", DW'(almost_empty_o), 1);
    check_eq("rst_count", DW'(count_o), 0);
    check_eq("rst_full", DW'(full_o), 0);
    check_eq("rst_dout", plain_data_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: key load, write 0..7, check ciphertext, read back
    load_key(KEY1);
    check_eq("t1_key", u_dut.r_key, KEY1);
    for (int i = 0; i < 8; i++) begin
      do_write(DW'(i));
      if (i == 1) check_eq("t1_aempty_c2", DW'(almost_empty_o), 1);
      if (i == 2) check_eq("t1_aempty_c3", DW'(almost_empty_o), 0);
    end
    check_eq("t1_count", DW'(count_o), 8);
    check_eq("t1_ciph0", u_dut.u_ram.r_mem[0][DW-1:0], KEY1);
    check_eq("t1_ciph1", u_dut.u_ram.r_mem[1][DW-1:0], CIPH1);
    check_eq("t1_tag1", DW'(u_dut.u_ram.r_mem[1][DW]), 1);
    for (int i = 0; i < 8; i++) do_read("t1_rd", DW'(i));
    step();
    check_eq("t1_valid_drop", DW'(rd_valid_o), 0);
    check_eq("t1_hold", plain_data_out, 7);
    check_eq("t1_empty", DW'(empty_o), 1);

    // 2: fill past full
    for (int i = 0; i < 17; i++) begin
      do_write(DW'(i));
      if (i == 12) check_eq("t2_afull_c13", DW'(almost_full_o), 0);
      if (i == 13) check_eq("t2_afull_c14", DW'(almost_full_o), 1);
      if (i == 14) check_eq("t2_full_c15", DW'(full_o), 0);
      if (i == 15) begin
        check_eq("t2_full", DW'(full_o), 1);
        check_eq("t2_ovf_pre", DW'(overflow_o), 0);
      end
    end
    check_eq("t2_count", DW'(count_o), 16);
    check_eq("t2_ovf", DW'(overflow_o), 1);
    for (int i = 0; i < 16; i++) do_read("t2_rd", DW'(i));
    check_eq("t2_empty", DW'(empty_o), 1);
    check_eq("t2_count0", DW'(count_o), 0);

    // 3: underflow and simultaneous ops
    check_eq("t3_udf_pre", DW'(underflow_o), 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check_eq("t3_udf", DW'(underflow_o), 1);
    check_eq("t3_novalid", DW'(rd_valid_o), 0);
    check_eq("t3_hold", plain_data_out, 15);
    plain_data_in = 128'hAA;
    wr_en = 1'b1;
    rd_en = 1'b1;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_eq("t3_sim_empty_cnt", DW'(count_o), 1);
    check_eq("t3_sim_empty_val", DW'(rd_valid_o), 0);
    do_read("t3_rd_aa", 128'hAA);
    for (int i = 0; i < 16; i++) do_write(DW'(200 + i));
    plain_data_in = DW'(216);
    wr_en = 1'b1;
    rd_en = 1'b1;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_eq("t3_sim_full_cnt", DW'(count_o), 16);
    check_eq("t3_sim_full_data", plain_data_out, DW'(200));
    check_eq("t3_sim_full_valid", DW'(rd_valid_o), 1);
    for (int i = 1; i < 17; i++) do_read("t3_order", DW'(200 + i));

    // 4: key load refused while not empty, then accepted
    for (int i = 0; i < 3; i++) do_write(DW'(300 + i));
    check_eq("t4_krej_pre", DW'(key_rej_o), 0);
    load_key(KEY2);
    check_eq("t4_krej", DW'(key_rej_o), 1);
    check_eq("t4_key_kept", u_dut.r_key, KEY1);
    for (int i = 0; i < 3; i++) do_read("t4_rd_old", DW'(300 + i));
    load_key(KEY2);
    check_eq("t4_key_new", u_dut.r_key, KEY2);
    for (int i = 0; i < 4; i++) do_write(DW'(100 + i));
    for (int i = 0; i < 4; i++) do_read("t4_rd_new", DW'(100 + i));

    // 5: long run across sequence wrap, then corrupted word
    for (int i = 0; i < 300; i++) begin
      do_write(DW'(1000 + i));
      do_read("t5_pair", DW'(1000 + i));
    end
    idx = u_dut.r_wr_ptr;
    do_write(128'h5A);
    u_dut.u_ram.r_mem[idx] = u_dut.u_ram.r_mem[idx] ^ 129'd1;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check_eq("t5_bad_valid", DW'(rd_valid_o), 1);
    check_eq("t5_bad_data", plain_data_out, 128'h5B);
    check_eq("t5_tag_err", DW'(tag_err_o), 1);
    step();
    check_eq("t5_tag_err_pulse", DW'(tag_err_o), 0);

    // 6: asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) do_write(DW'(50 + i));
    check_eq("t6_count5", DW'(count_o), 5);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_count", DW'(count_o), 0);
    check_eq("t6_empty", DW'(empty_o), 1);
    check_eq("t6_aempty", DW'(almost_empty_o), 1);
    check_eq("t6_afull", DW'(almost_full_o), 0);
    check_eq("t6_ovf", DW'(overflow_o), 0);
    check_eq("t6_udf", DW'(underflow_o), 0);
    check_eq("t6_krej", DW'(key_rej_o), 0);
    check_eq("t6_dout", plain_data_out, 0);
    check_eq("t6_key", u_dut.r_key, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check_eq("t6_post_valid", DW'(rd_valid_o), 0);
    check_eq("t6_post_udf", DW'(underflow_o), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
